// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage_if : fetch-stage bus (control, imem port, IF/ID outputs)  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_instr;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        fetch_halted;
  logic [15:0] fetch_cnt;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, imem_rd_en, if_id_instr, if_id_pc, if_id_pc1,
           if_id_valid, fetch_halted, fetch_cnt
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, imem_rd_en, if_id_instr, if_id_pc, if_id_pc1,
           if_id_valid, fetch_halted, fetch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage : IF stage with PC, halt FSM and IF/ID pipeline register  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [3:0]  HLT_OP    = 4'hF,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [15:0] RST_PC    = 16'h0000
) (
  input  wire            clk,
  input  wire            rst,
  fetch_stage_if.master  bus
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] ifpc1_q, ifpc1_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RST_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 16'h0000;
      ifpc1_q <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc1_q <= ifpc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: redirect > stall > HALT > normal fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc1_d = ifpc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = S_RUN;
    end else if (bus.stall) begin
      state_d = state_q;
    end else if (state_q == S_HALT) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      instr_d = bus.imem_instr;
      ifpc_d  = pc_q;
      ifpc1_d = pc_q + 16'd1;
      valid_d = 1'b1;
      cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      // A fetched HLT is delivered once; the PC parks on it
      if (bus.imem_instr[15:12] == HLT_OP) begin
        state_d = S_HALT;
      end else begin
        pc_d = pc_q + 16'd1;
      end
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.imem_rd_en   = (state_q == S_RUN) && !bus.stall;
  assign bus.if_id_instr  = instr_q;
  assign bus.if_id_pc     = ifpc_q;
  assign bus.if_id_pc1    = ifpc1_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.fetch_halted = (state_q == S_HALT);
  assign bus.fetch_cnt    = cnt_q;

endmodule
`default_nettype wire
